// File: rtl/mltp_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
package mltp_pkg;

    localparam int unsigned MltpWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StShift
    } mltp_state_e;

endpackage

// File: rtl/mltp_ctrl.sv
// Sequencer for the multiplier: state register, iteration counter and datapath enables.
module mltp_ctrl
    import mltp_pkg::*;
#(
    parameter int unsigned N = MltpWidth,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          start_i,
    output logic          load_o,
    output logic          add_o,
    output logic          shift_o,
    output logic [PW-1:0] p_o
);

    mltp_state_e   state_q, state_d;
    logic [PW-1:0] p_q, p_d;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        load_o  = 1'b0;
        add_o   = 1'b0;
        shift_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    p_d     = PW'(N - 1);
                    state_d = StAdd;
                end
            end
            StAdd: begin
                add_o   = 1'b1;
                state_d = StShift;
            end
            StShift: begin
                shift_o = 1'b1;
                if (p_q == '0) begin
                    state_d = StIdle;
                end else begin
                    p_d     = p_q - PW'(1);
                    state_d = StAdd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= StIdle;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/binary_mltp.sv
// Sequential shift-and-add unsigned multiplier; product formed in {A,Q}.
// Optional MLTP_DONE_EN adds a one-cycle Done pulse on return to idle.
module binary_mltp
    import mltp_pkg::*;
#(
    parameter int unsigned N = MltpWidth,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          Clr,
    input  logic          S,
    input  logic [N-1:0]  Binput,
    input  logic [N-1:0]  Qinput,
    output logic          C,
    output logic [N-1:0]  A,
    output logic [N-1:0]  Q,
    output logic [PW-1:0] P
`ifdef MLTP_DONE_EN
    ,
    output logic          Done
`endif
);

    logic         load_en, add_en, shift_en;
    logic [N-1:0] a_q, a_d, b_q, b_d, q_q, q_d;
    logic         c_q, c_d;
    logic [N:0]   sum;

    mltp_ctrl #(
        .N(N)
    ) u_ctrl (
        .clk_i  (CLK),
        .clr_i  (Clr),
        .start_i(S),
        .load_o (load_en),
        .add_o  (add_en),
        .shift_o(shift_en),
        .p_o    (P)
    );

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        q_d = q_q;
        c_d = c_q;
        if (load_en) begin
            b_d = Binput;
            q_d = Qinput;
            a_d = '0;
            c_d = 1'b0;
        end else if (add_en) begin
            if (q_q[0]) begin
                {c_d, a_d} = sum;
            end
        end else if (shift_en) begin
            {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (Clr) begin
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
            c_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            q_q <= q_d;
            c_q <= c_d;
        end
    end

    assign A = a_q;
    assign Q = q_q;
    assign C = c_q;

`ifdef MLTP_DONE_EN
    logic done_q, done_d;

    // Final SHIFT is the one seen with the counter already at zero.
    assign done_d = shift_en && (P == '0);

    always_ff @(posedge CLK) begin
        if (Clr) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign Done = done_q;
`endif

endmodule

// File: tb/tb_binary_mltp.sv
// Self-checking bench for binary_mltp with a product scoreboard.
module tb_binary_mltp;

    localparam int unsigned N  = 8;
    localparam int unsigned PW = $clog2(N);

    logic          CLK = 1'b0;
    logic          Clr = 1'b0;
    logic          S = 1'b0;
    logic [N-1:0]  Binput = '0;
    logic [N-1:0]  Qinput = '0;
    logic          C;
    logic [N-1:0]  A;
    logic [N-1:0]  Q;
    logic [PW-1:0] P;
`ifdef MLTP_DONE_EN
    logic          Done;
`endif

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q[$];

    binary_mltp #(
        .N(N)
    ) dut (
        .CLK   (CLK),
        .Clr   (Clr),
        .S     (S),
        .Binput(Binput),
        .Qinput(Qinput),
        .C     (C),
        .A     (A),
        .Q     (Q),
        .P     (P)
`ifdef MLTP_DONE_EN
        ,
        .Done  (Done)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves S low after the sampling edge.
    task automatic launch(input logic [N-1:0] b, input logic [N-1:0] q);
        logic [2*N-1:0] bw, qw;
        bw = {{N{1'b0}}, b};
        qw = {{N{1'b0}}, q};
        Binput = b;
        Qinput = q;
        S = 1'b1;
        exp_q.push_back(bw * qw);
        @(posedge CLK);
        #1 S = 1'b0;
    endtask

    // Waits the remaining edges to completion, then pops and compares the result.
    task automatic finish(input string tag, input int edges);
        logic [2*N-1:0] exp;
        repeat (edges - 1) @(posedge CLK);
        @(negedge CLK);
`ifdef MLTP_DONE_EN
        check({tag, "_done_early"}, 32'(Done), 32'd0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_prod"}, 32'({A, Q}), 32'(exp));
            check({tag, "_c"}, 32'(C), 32'd0);
            check({tag, "_p"}, 32'(P), 32'd0);
        end
`ifdef MLTP_DONE_EN
        check({tag, "_done"}, 32'(Done), 32'd1);
`endif
    endtask

    initial begin
        logic [2*N-1:0] held;

        // Reset and idle hold
        @(negedge CLK);
        Clr = 1'b1;
        @(posedge CLK);
        #1 Clr = 1'b0;
        @(negedge CLK);
        check("rst_a", 32'(A), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_c", 32'(C), 32'd0);
        check("rst_p", 32'(P), 32'd0);
`ifdef MLTP_DONE_EN
        check("rst_done", 32'(Done), 32'd0);
`endif
        Binput = 8'h55;
        Qinput = 8'h33;
        repeat (3) @(negedge CLK);
        check("idle_hold", 32'({C, A, Q, P}), 32'd0);

        launch(8'hEF, 8'hFE);
        finish("ef_fe", 16);
        check("ef_fe_a", 32'(A), 32'h00ED);
        check("ef_fe_q", 32'(Q), 32'h0022);
`ifdef MLTP_DONE_EN
        @(negedge CLK);
        check("done_one_cycle", 32'(Done), 32'd0);
`endif

        // Result held in idle while S stays low
        held = {A, Q};
        Binput = 8'h12;
        Qinput = 8'h34;
        repeat (3) @(negedge CLK);
        check("held", 32'({A, Q}), 32'(held));

        @(negedge CLK);
        launch(8'hFF, 8'hFF);
        finish("ff_ff", 16);
        check("ff_ff_const", 32'({A, Q}), 32'hFE01);

        @(negedge CLK);
        launch(8'h00, 8'hA5);
        finish("zero_b", 16);
        @(negedge CLK);
        launch(8'hA5, 8'h00);
        finish("zero_q", 16);

        // Operand and start changes mid-operation are ignored
        @(negedge CLK);
        launch(8'h5A, 8'h3C);
        repeat (5) @(posedge CLK);
        #1;
        Binput = 8'hC3;
        Qinput = 8'h81;
        S = 1'b1;
        @(posedge CLK);
        #1 S = 1'b0;
        @(negedge CLK);
        check("mid_p", 32'(P), 32'd4);
        finish("midop", 10);
        check("midop_const", 32'({A, Q}), 32'h1518);

        // Clear in the middle of an operation aborts it
        @(negedge CLK);
        launch(8'h77, 8'h99);
        repeat (5) @(posedge CLK);
        #1 Clr = 1'b1;
        @(posedge CLK);
        #1 Clr = 1'b0;
        void'(exp_q.pop_back());
        @(negedge CLK);
        check("abort_zero", 32'({C, A, Q, P}), 32'd0);
        repeat (2) @(negedge CLK);
        check("abort_idle", 32'({C, A, Q, P}), 32'd0);
        launch(8'h0D, 8'h0B);
        finish("after_clr", 16);

        // S held high: back-to-back operations
        @(negedge CLK);
        Binput = 8'hC8;
        Qinput = 8'h07;
        S = 1'b1;
        exp_q.push_back(16'(8'hC8) * 16'(8'h07));
        @(posedge CLK);
        finish("b2b_first", 16);
        Binput = 8'h2B;
        Qinput = 8'hD4;
        exp_q.push_back(16'(8'h2B) * 16'(8'hD4));
        @(posedge CLK);
        #1 S = 1'b0;
        finish("b2b_second", 16);

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            launch(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            finish("rand", 16);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
